fsm_5: RTL and testbench
========================

# fsm_5

Serial divisibility detector: accepts an unsigned binary number one bit per clock, MSB first, and flags whenever the value accumulated so far is an exact multiple of DIVISOR (default 5). It tracks only the running remainder, so the input stream may be arbitrarily long. It is a leaf block driven directly by a serial bit source; dout feeds downstream control logic.

## Interface
- DIVISOR, default 5: modulus tested; legal range 2..256. Remainder register width is ceil(log2(DIVISOR)), 3 bits at the default.
- clk  input  1  rising-edge clock; all state changes on this edge only.
- reset_n  input  1  synchronous, active-high reset. The name is kept for codebase compatibility: 1 = reset, despite the suffix.
- din  input  1  next bit of the number, MSB first, sampled every rising edge that is not a reset edge.
- dout  output  1  1 when the number received since the last reset is divisible by DIVISOR; 0 otherwise.

## Operation
- State: remainder r in 0..DIVISOR-1, held in a register.
- Update every non-reset edge: r_next = (2*r + din) mod DIVISOR.
  - Implement with compare-and-subtract. 2*r + din < 2*DIVISOR, so a single conditional subtract of DIVISOR is sufficient. No divider.
- Default DIVISOR=5 state table (state = remainder; din=0 / din=1):
  - S0 -> S0 / S1
  - S1 -> S2 / S3
  - S2 -> S4 / S0
  - S3 -> S1 / S2
  - S4 -> S3 / S4
- Output is Moore: dout = (r == 0), decoded from the state register only. din has no combinational path to dout.
- Reset: r <= 0 at the edge where reset_n=1. This represents the empty number, value 0, so dout = 1 in reset and immediately after.
- Reset has priority over din. din is ignored on any edge where reset_n=1.
- Reset mid-stream discards all previous bits. The next number starts with the first din sampled after reset deasserts.
- Leading zeros are legal. They leave r at 0 and dout at 1.
- No overflow condition exists, because only the remainder is stored.
- State encoding is free. Unreachable encodings (values >= DIVISOR) must recover to S0 on the next edge.

## Timing
- Latency: the din sampled at edge k is reflected in dout after edge k, i.e. from cycle k+1. This is one cycle of latency.
- dout changes only just after rising clk edges and is glitch-free with respect to din.
- Reset is synchronous. Asserting reset_n between edges has no effect until the next rising edge.
- Before the first reset edge, r and dout are undefined. The bench must apply reset first.
- Throughput: one bit per cycle, with no stall or handshake.

## Test plan
- Reset for 2 cycles with din=1 -> dout=1 after the reset edge, r=0, din ignored.
- Stream 1,0,1 (value 5) -> dout 0,0,1 after each respective edge.
- Stream 1,0,1,0,1,0,1 (value 85) -> remainders 1,2,0,0,1,2,0; dout 0,0,1,1,0,0,1.
- Stream 1,1,1,1 (value 15) -> remainders 1,3,2,0; dout 0,0,0,1.
- Stream 1,1 (r=3), then assert reset_n for one edge, then stream 0,0,0 -> dout=1 from the reset edge onward.
- Exhaustive check: all 8-bit values streamed MSB first, each preceded by reset -> dout after the 8th bit equals (value % 5 == 0). Repeat with DIVISOR=3 and DIVISOR=7.

Source files
------------

// File: rtl/fsm_5.sv
// Serial MSB-first divisibility detector: tracks (value mod DIVISOR) one bit per clock.
// dout reflects each bit one cycle after it is sampled. There is no backpressure: one bit is accepted every cycle.
module fsm_5 #(
  parameter int unsigned DIVISOR = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned W = $clog2(DIVISOR);
  localparam logic [W:0]  DIV_EXT = (W+1)'(DIVISOR);

  logic [W-1:0] r_q;
  logic [W-1:0] r_d;
  logic [W:0]   dbl;

  // reset_n is active-high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  // 2*r + din < 2*DIVISOR, so one conditional subtract yields the remainder.
  // Out-of-range encodings fall back to the empty-number state.
  always_comb begin
    dbl = {r_q, din};
    r_d = '0;
    if ({1'b0, r_q} >= DIV_EXT) begin
      r_d = '0;
    end else if (dbl >= DIV_EXT) begin
      r_d = W'(dbl - DIV_EXT);
    end else begin
      r_d = dbl[W-1:0];
    end
  end

  always_comb begin
    dout = (r_q == '0);
  end

endmodule

// File: tb/tb_fsm_5.sv
// Directed bench for fsm_5: hand-computed streams plus exhaustive 8-bit sweep at divisors 5, 3 and 7.
module tb_fsm_5;

  logic clk;
  logic reset_n;
  logic din;
  logic dout5;
  logic dout3;
  logic dout7;

  int n_cmp;
  int n_err;

  fsm_5 #(.DIVISOR(5)) dut5 (.clk(clk), .reset_n(reset_n), .din(din), .dout(dout5));
  fsm_5 #(.DIVISOR(3)) dut3 (.clk(clk), .reset_n(reset_n), .din(din), .dout(dout3));
  fsm_5 #(.DIVISOR(7)) dut7 (.clk(clk), .reset_n(reset_n), .din(din), .dout(dout7));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive between edges, then let one rising edge pass and settle.
  task automatic step(input logic rst, input logic d);
    @(negedge clk);
    reset_n = rst;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  // bits[n-1] is streamed first; exp[i] is dout after bits[i] is clocked in.
  task automatic stream(input string tag, input int n, input logic [15:0] bits,
                        input logic [15:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b0, bits[i]);
      check($sformatf("%s[%0d]", tag, n - 1 - i), dout5, exp[i]);
    end
  endtask

  initial begin
    logic [7:0] v;
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b1;
    din     = 1'b1;

    // Reset held two edges with din=1: din must be ignored.
    step(1'b1, 1'b1);
    check("reset_edge0", dout5, 1'b1);
    step(1'b1, 1'b1);
    check("reset_edge1", dout5, 1'b1);

    stream("val5", 3, 16'b101, 16'b001);

    step(1'b1, 1'b0);
    check("reset_a", dout5, 1'b1);
    stream("val85", 7, 16'b1010101, 16'b0011001);

    // din toggling between edges must not reach dout.
    @(negedge clk);
    din = 1'b1;
    #2;
    check("no_comb_path", dout5, 1'b1);

    step(1'b1, 1'b0);
    stream("val15", 4, 16'b1111, 16'b0001);

    step(1'b1, 1'b0);
    stream("lead_zero", 2, 16'b00, 16'b11);

    // Mid-stream reset discards r=3.
    step(1'b1, 1'b0);
    stream("pre_rst", 2, 16'b11, 16'b00);
    step(1'b1, 1'b1);
    check("mid_reset", dout5, 1'b1);
    stream("post_rst", 3, 16'b000, 16'b111);

    // A reset pulse that misses the edge has no effect: r=3 -> (6+0)%5=1.
    step(1'b1, 1'b0);
    stream("glitch_pre", 2, 16'b11, 16'b00);
    @(negedge clk);
    din     = 1'b0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_between_edges", dout5, 1'b0);

    for (int val = 0; val < 256; val++) begin
      v = 8'(val);
      step(1'b1, 1'b0);
      for (int b = 7; b >= 0; b--) begin
        step(1'b0, v[b]);
      end
      check($sformatf("sweep5_%0d", val), dout5, (val % 5) == 0);
      check($sformatf("sweep3_%0d", val), dout3, (val % 3) == 0);
      check($sformatf("sweep7_%0d", val), dout7, (val % 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
